// File: rtl/brlite_svc_buffer_pkg.sv
// BrLite service-message types shared by the BrLite router side and the DMNI.
// The package is named DMNIPkg because the NI MMR block already imports it
// for the same message layout.
package DMNIPkg;

    localparam int BRLITE_KSVC_W    = 8;
    localparam int BRLITE_SEQ_W     = 16;
    localparam int BRLITE_PRODUCER_W = 16;
    localparam int BRLITE_PAYLOAD_W = 32;

    // One service message as carried on the router local port.
    typedef struct packed {
        logic [BRLITE_KSVC_W-1:0]     ksvc;
        logic [BRLITE_SEQ_W-1:0]      seq_source;
        logic [BRLITE_PRODUCER_W-1:0] producer;
        logic [BRLITE_PAYLOAD_W-1:0]  payload;
    } brlite_svc_t;

    localparam int BRLITE_SVC_W = $bits(brlite_svc_t);

endpackage

// File: rtl/brlite_svc_buffer_fifo.sv
// brlite_svc_fifo: generic circular buffer with push/pop/full/empty/count.
// Push while full and pop while empty are ignored. Both are judged on the
// registered count, so at full a simultaneous push/pop only pops, and at
// empty a simultaneous push/pop only pushes. Storage is not reset.
module brlite_svc_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 72,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign rdata_o = mem[head_q];
    assign count_o = count_q;

    // Storage write; contents survive reset on purpose.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[tail_q] <= wdata_i;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) begin
                tail_q <= tail_q + PTR_W'(1);
            end
            if (pop_ok) begin
                head_q <= head_q + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/brlite_svc_buffer.sv
// brlite_svc_buffer: receive-side buffer between the BrLite router local
// output and the DMNI MMR block.
// Optional statistics (rcv_count_o, high_water_o) with BRLITE_SVC_STATS_EN.
//
// Handshake: the router raises rx_i with data_i and holds both until it sees
// ack_o. A message is captured on the edge where rx_i && !ack_o && !full;
// ack_o then pulses for exactly the following cycle, during which rx_i is
// ignored because the router only drops it on the edge that samples ack_o.
// Toward the NI, rx_o means "head entry valid on data_o"; a one-cycle ack_i
// pops it, and ack_i while empty does nothing.
module brlite_svc_buffer
    import DMNIPkg::*;
#(
    parameter int BUFFER_SIZE = 8,
    localparam int CNT_W = $clog2(BUFFER_SIZE) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             rx_i,
    output logic             ack_o,
    input  brlite_svc_t      data_i,
    output logic             rx_o,
    input  logic             ack_i,
    output brlite_svc_t      data_o,
    output logic [CNT_W-1:0] count_o
`ifdef BRLITE_SVC_STATS_EN
    ,
    output logic [31:0]      rcv_count_o,
    output logic [CNT_W-1:0] high_water_o
`endif
);

    logic                    push;
    logic                    full;
    logic                    empty;
    logic [BRLITE_SVC_W-1:0] rdata;

    assign push   = rx_i && !ack_o && !full;
    assign rx_o   = !empty;
    assign data_o = brlite_svc_t'(rdata);

    brlite_svc_fifo #(
        .DEPTH (BUFFER_SIZE),
        .WIDTH (BRLITE_SVC_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .wdata_i (data_i),
        .pop_i   (ack_i),
        .rdata_o (rdata),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count_o)
    );

    // Ack pulse: one cycle after each capture, which also masks rx_i.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ack_o <= 1'b0;
        end else begin
            ack_o <= push;
        end
    end

`ifdef BRLITE_SVC_STATS_EN
    logic             pop_ok;
    logic [CNT_W-1:0] count_nxt;

    assign pop_ok    = ack_i && !empty;
    assign count_nxt = count_o + CNT_W'(push) - CNT_W'(pop_ok);

    // Accepted-message counter (wraps) and peak occupancy after each edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rcv_count_o  <= '0;
            high_water_o <= '0;
        end else begin
            if (push) begin
                rcv_count_o <= rcv_count_o + 32'd1;
            end
            if (count_nxt > high_water_o) begin
                high_water_o <= count_nxt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_brlite_svc_buffer.sv
// Self-checking bench for brlite_svc_buffer (BUFFER_SIZE = 8).
// Checks the statistics ports as well when BRLITE_SVC_STATS_EN is defined.
module tb_brlite_svc_buffer;
  import DMNIPkg::*;

  localparam int N  = 8;
  localparam int CW = $clog2(N) + 1;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          rx_i;
  logic          ack_o;
  brlite_svc_t   data_i;
  logic          rx_o;
  logic          ack_i;
  brlite_svc_t   data_o;
  logic [CW-1:0] count_o;
`ifdef BRLITE_SVC_STATS_EN
  logic [31:0]   rcv_count_o;
  logic [CW-1:0] high_water_o;
`endif

  brlite_svc_buffer #(.BUFFER_SIZE(N)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .rx_i         (rx_i),
    .ack_o        (ack_o),
    .data_i       (data_i),
    .rx_o         (rx_o),
    .ack_i        (ack_i),
    .data_o       (data_o),
    .count_o      (count_o)
`ifdef BRLITE_SVC_STATS_EN
    ,
    .rcv_count_o  (rcv_count_o),
    .high_water_o (high_water_o)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk_i = ~clk_i;

  // ---------------- scoreboard state ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  logic [BRLITE_SVC_W-1:0] exp_q[$];   // messages the buffer should hold, oldest first
  brlite_svc_t             send_q[$];  // messages the router still has to deliver
  logic                    m_ack;
  int unsigned             m_rcv;
  int                      m_hw;

  typedef struct {
    logic          rx;
    logic          ai;
    brlite_svc_t   din;
    logic          exp_ack;
    logic [CW-1:0] exp_cnt;
    logic          exp_rx;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic brlite_svc_t mk(input logic [7:0] k, input logic [15:0] s,
                                     input logic [15:0] p, input logic [31:0] pl);
    brlite_svc_t m;
    m.ksvc = k;
    m.seq_source = s;
    m.producer = p;
    m.payload = pl;
    return m;
  endfunction

  function automatic brlite_svc_t rnd_msg();
    return mk(8'($urandom), 16'($urandom), 16'($urandom), $urandom);
  endfunction

  // ---------------- driver tasks ----------------
  // Well-behaved router: presents the front of send_q, drops it on the edge that sees ack_o.
  task automatic drive_router();
    rx_i   = (send_q.size() > 0);
    data_i = (send_q.size() > 0) ? send_q[0] : '0;
  endtask

  task automatic compare_model();
    check("ack_o", 72'(ack_o), 72'(m_ack));
    check("count_o", 72'(count_o), 72'(exp_q.size()));
    check("rx_o", 72'(rx_o), 72'(exp_q.size() != 0));
    if (exp_q.size() != 0) check("data_o", data_o, exp_q[0]);
`ifdef BRLITE_SVC_STATS_EN
    check("rcv_count_o", 72'(rcv_count_o), 72'(m_rcv));
    check("high_water_o", 72'(high_water_o), 72'(m_hw));
`endif
  endtask

  // One clock: update the reference queue from the inputs applied this cycle, then compare.
  task automatic tick(input logic ai);
    logic pre_ack;
    logic push;
    logic pop;
    ack_i = ai;
    drive_router();
    pre_ack = ack_o;
    if (rst_i) begin
      exp_q.delete();
      m_ack = 1'b0;
      m_rcv = 0;
      m_hw  = 0;
    end else begin
      push = rx_i && !m_ack && (exp_q.size() < N);
      pop  = ack_i && (exp_q.size() > 0);
      if (pop) void'(exp_q.pop_front());
      if (push) begin
        exp_q.push_back(data_i);
        m_rcv++;
      end
      m_ack = push;
      if (exp_q.size() > m_hw) m_hw = exp_q.size();
    end
    @(posedge clk_i);
    #1;
    if (pre_ack === 1'b1 && send_q.size() > 0) void'(send_q.pop_front());
    compare_model();
    ack_i = 1'b0;
    drive_router();
  endtask

  task automatic reset_dut();
    send_q.delete();
    rst_i = 1'b1;
    tick(1'b0);
    rst_i = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0);
  endtask

  // ---------------- test sequence ----------------
  brlite_svc_t m0;

  initial begin
    rst_i  = 1'b0;
    rx_i   = 1'b0;
    ack_i  = 1'b0;
    data_i = '0;
    m_ack  = 1'b0;
    m_rcv  = 0;
    m_hw   = 0;

    m0 = mk(8'h12, 16'h0001, 16'h0101, 32'hDEADBEEF);
    // single message, router holding rx_i too long, pops, then a pop on empty
    vecs[0] = '{1'b1, 1'b0, m0, 1'b1, CW'(1), 1'b1};
    vecs[1] = '{1'b1, 1'b0, m0, 1'b0, CW'(1), 1'b1};
    vecs[2] = '{1'b1, 1'b0, m0, 1'b1, CW'(2), 1'b1};
    vecs[3] = '{1'b0, 1'b0, m0, 1'b0, CW'(2), 1'b1};
    vecs[4] = '{1'b0, 1'b1, m0, 1'b0, CW'(1), 1'b1};
    vecs[5] = '{1'b0, 1'b1, m0, 1'b0, CW'(0), 1'b0};
    vecs[6] = '{1'b0, 1'b1, m0, 1'b0, CW'(0), 1'b0};
    vecs[7] = '{1'b0, 1'b0, m0, 1'b0, CW'(0), 1'b0};

    repeat (2) @(posedge clk_i);
    #1;
    reset_dut();
    check("reset ack_o", 72'(ack_o), 72'(0));
    check("reset rx_o", 72'(rx_o), 72'(0));
    check("reset count_o", 72'(count_o), 72'(0));

    // table-driven vectors
    for (int i = 0; i < 8; i++) begin
      rx_i   = vecs[i].rx;
      ack_i  = vecs[i].ai;
      data_i = vecs[i].din;
      @(posedge clk_i);
      #1;
      check($sformatf("vec%0d ack_o", i), 72'(ack_o), 72'(vecs[i].exp_ack));
      check($sformatf("vec%0d count_o", i), 72'(count_o), 72'(vecs[i].exp_cnt));
      check($sformatf("vec%0d rx_o", i), 72'(rx_o), 72'(vecs[i].exp_rx));
      if (vecs[i].exp_rx) check($sformatf("vec%0d data_o", i), data_o, vecs[i].din);
    end
    rx_i  = 1'b0;
    ack_i = 1'b0;

    // full FIFO: payloads 0..8, the 9th stalls until one pop
    reset_dut();
    for (int k = 0; k < 9; k++) send_q.push_back(mk(8'h20, 16'(k), 16'h0202, 32'(k)));
    idle(25);
    check("full count_o", 72'(count_o), 72'(N));
    check("full ack_o", 72'(ack_o), 72'(0));
    check("full stalled", 72'(send_q.size()), 72'(1));
    tick(1'b1);
    check("pop at full ack_o", 72'(ack_o), 72'(0));
    tick(1'b0);
    check("9th accepted ack_o", 72'(ack_o), 72'(1));
    for (int k = 1; k <= 8; k++) begin
      check($sformatf("drain payload %0d", k), 72'(data_o.payload), 72'(k));
      tick(1'b1);
      tick(1'b0);
    end
    check("drained count_o", 72'(count_o), 72'(0));

    // same-cycle push and pop at count 3
    reset_dut();
    for (int k = 0; k < 3; k++) send_q.push_back(rnd_msg());
    idle(10);
    check("pre-collision count_o", 72'(count_o), 72'(3));
    send_q.push_back(rnd_msg());
    tick(1'b1);
    check("collision count_o", 72'(count_o), 72'(3));
    check("collision ack_o", 72'(ack_o), 72'(1));

    // reset with 5 stored discards them
    reset_dut();
    for (int k = 0; k < 5; k++) send_q.push_back(rnd_msg());
    idle(15);
    check("pre-reset count_o", 72'(count_o), 72'(5));
    rst_i = 1'b1;
    tick(1'b0);
    rst_i = 1'b0;
    check("post-reset count_o", 72'(count_o), 72'(0));
    check("post-reset rx_o", 72'(rx_o), 72'(0));

    // 20 interleaved messages across pointer wrap
    reset_dut();
    for (int k = 0; k < 20; k++) send_q.push_back(rnd_msg());
    for (int c = 0; c < 600 && !(send_q.size() == 0 && exp_q.size() == 0); c++) begin
      tick(1'($urandom_range(0, 1)));
    end
    check("wrap drained", 72'(send_q.size() + exp_q.size()), 72'(0));

    // longer random run with varying NI pop pressure
    reset_dut();
    for (int k = 0; k < 200; k++) send_q.push_back(rnd_msg());
    for (int c = 0; c < 4000 && !(send_q.size() == 0 && exp_q.size() == 0); c++) begin
      if (c < 600) tick(1'($urandom_range(0, 3) == 0));
      else         tick(1'($urandom_range(0, 2) != 0));
    end
    check("random drained", 72'(send_q.size() + exp_q.size()), 72'(0));

`ifdef BRLITE_SVC_STATS_EN
    // 5 pushes, 2 pops, 3 pushes
    reset_dut();
    for (int k = 0; k < 5; k++) send_q.push_back(rnd_msg());
    idle(12);
    tick(1'b1);
    tick(1'b0);
    tick(1'b1);
    tick(1'b0);
    for (int k = 0; k < 3; k++) send_q.push_back(rnd_msg());
    idle(10);
    check("stats rcv_count_o", 72'(rcv_count_o), 72'(8));
    check("stats high_water_o", 72'(high_water_o), 72'(6));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
